// File: rtl/shift_sequencer.sv
// Round-robin two-requester shift controller driving a single-step shifter.
// Optional rotate support is enabled by defining SHIFT_SEQ_ROTATE_EN.
module shift_sequencer #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             ctrl0,
    input  logic             ctrl1,
    input  logic [AMT_W-1:0] amt0,
    input  logic [AMT_W-1:0] amt1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic             rot0,
    input  logic             rot1,
    output logic             ack0,
    output logic             ack1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] Answer
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] shifted;
    logic [AMT_W-1:0] count;
    logic             dir;
    logic             cur_id;
    logic             last_grant;
    logic             rot_mode;
    logic             grant0;
    logic             grant1;

    // On a tie the requester not served last wins; last_grant resets to 1 so req0 wins first.
    assign grant0 = req0 && (!req1 || last_grant);
    assign grant1 = req1 && (!req0 || !last_grant);

`ifndef SHIFT_SEQ_ROTATE_EN
    logic unused_rot;
    assign unused_rot = rot0 | rot1;
    assign rot_mode   = 1'b0;
`endif

    // dir: 0 = left, 1 = right; the fill bit is 0 unless rotating.
    assign shifted = dir ? {rot_mode & work[0], work[WIDTH-1:1]}
                         : {work[WIDTH-2:0], rot_mode & work[WIDTH-1]};

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            work       <= '0;
            count      <= '0;
            dir        <= 1'b0;
            cur_id     <= 1'b0;
            last_grant <= 1'b1;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            done_id    <= 1'b0;
            Answer     <= '0;
`ifdef SHIFT_SEQ_ROTATE_EN
            rot_mode   <= 1'b0;
`endif
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant1) begin
                        work       <= a1;
                        count      <= amt1;
                        dir        <= ctrl1;
                        cur_id     <= 1'b1;
                        last_grant <= 1'b1;
                        ack1       <= 1'b1;
                        state      <= SHIFT;
`ifdef SHIFT_SEQ_ROTATE_EN
                        rot_mode   <= rot1;
`endif
                    end else if (grant0) begin
                        work       <= a0;
                        count      <= amt0;
                        dir        <= ctrl0;
                        cur_id     <= 1'b0;
                        last_grant <= 1'b0;
                        ack0       <= 1'b1;
                        state      <= SHIFT;
`ifdef SHIFT_SEQ_ROTATE_EN
                        rot_mode   <= rot0;
`endif
                    end
                end
                SHIFT: begin
                    if (count != '0) begin
                        work  <= shifted;
                        count <= count - 1'b1;
                    end else begin
                        Answer  <= work;
                        done_id <= cur_id;
                        state   <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: stimulus pushes expected results, a monitor
// pops and compares on every done pulse.
module tb_shift_sequencer;

    typedef struct packed {
        logic        id;
        logic [15:0] ans;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic        ctrl0 = 1'b0, ctrl1 = 1'b0;
    logic [3:0]  amt0 = '0, amt1 = '0;
    logic [15:0] a0 = '0, a1 = '0;
    logic        rot0 = 1'b0, rot1 = 1'b0;
    logic        ack0, ack1, busy, done, done_id;
    logic [15:0] Answer;

    exp_t sb[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    shift_sequencer #(.WIDTH(16), .AMT_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .ctrl0(ctrl0), .ctrl1(ctrl1),
        .amt0(amt0), .amt1(amt1),
        .a0(a0), .a1(a1),
        .rot0(rot0), .rot1(rot1),
        .ack0(ack0), .ack1(ack1),
        .busy(busy), .done(done), .done_id(done_id),
        .Answer(Answer)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done && !rst) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("done_id", 32'(done_id), 32'(e.id));
                    check("answer", 32'(Answer), 32'(e.ans));
                end
            end
        end
    end

    task automatic set_inputs(input logic id, input logic [15:0] a, input logic ctrl,
                              input logic [3:0] amt, input logic rot);
        if (id) begin
            a1 = a; ctrl1 = ctrl; amt1 = amt; rot1 = rot; req1 = 1'b1;
        end else begin
            a0 = a; ctrl0 = ctrl; amt0 = amt; rot0 = rot; req0 = 1'b1;
        end
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 60; i++) begin
            if (!busy) break;
            @(posedge clk);
            #1;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    // Single request: checks ack/busy after E0, done latency amt+1 and IDLE at E(amt+2).
    task automatic run_op(input string name, input logic id, input logic [15:0] a,
                          input logic ctrl, input logic [3:0] amt, input logic rot,
                          input logic [15:0] exp_ans);
        int lat;
        @(negedge clk);
        set_inputs(id, a, ctrl, amt, rot);
        sb.push_back('{id: id, ans: exp_ans});
        @(posedge clk);
        #1;
        check({name, "_ack"}, {30'd0, ack1, ack0}, id ? 32'd2 : 32'd1);
        check({name, "_busy"}, 32'(busy), 32'd1);
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        check({name, "_latency"}, 32'(lat), 32'(amt) + 32'd1);
        @(posedge clk);
        #1;
        check({name, "_idle"}, {30'd0, busy, done}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    // Both requesters high together; req0 is expected to win, req1 follows.
    task automatic tie_run(input string name, input logic [15:0] x0, input logic c0,
                           input logic [15:0] e0, input logic [15:0] x1, input logic c1,
                           input logic [15:0] e1);
        @(negedge clk);
        set_inputs(1'b0, x0, c0, 4'd2, 1'b0);
        set_inputs(1'b1, x1, c1, 4'd2, 1'b0);
        sb.push_back('{id: 1'b0, ans: e0});
        sb.push_back('{id: 1'b1, ans: e1});
        @(posedge clk);
        #1;
        check({name, "_first_grant"}, {30'd0, ack1, ack0}, 32'd1);
        @(negedge clk);
        req0 = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (ack1) break;
        end
        check({name, "_second_grant"}, {30'd0, ack1, ack0}, 32'd2);
        @(negedge clk);
        req1 = 1'b0;
        wait_idle({name, "_idle"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] rot_l_exp, rot_r_exp;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ack", {30'd0, ack1, ack0}, 32'd0);
        check("rst_answer", 32'(Answer), 32'd0);
        check("rst_done_id", 32'(done_id), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fresh reset: first tie goes to req0, then req1, then req0 again.
        tie_run("tie1", 16'h0003, 1'b0, 16'h000C, 16'h0100, 1'b1, 16'h0040);
        tie_run("tie2", 16'h0005, 1'b0, 16'h0014, 16'h8000, 1'b1, 16'h2000);

        run_op("left1", 1'b0, 16'd10, 1'b0, 4'd1, 1'b0, 16'd20);
        run_op("right3", 1'b1, 16'd9, 1'b1, 4'd3, 1'b0, 16'd1);
        run_op("amt0", 1'b0, 16'hBEEF, 1'b0, 4'd0, 1'b0, 16'hBEEF);
        run_op("amt15", 1'b1, 16'h0001, 1'b0, 4'd15, 1'b0, 16'h8000);

`ifdef SHIFT_SEQ_ROTATE_EN
        rot_l_exp = 16'h0003;
        rot_r_exp = 16'h8000;
`else
        rot_l_exp = 16'h0002;
        rot_r_exp = 16'h0000;
`endif
        run_op("rot_left", 1'b0, 16'h8001, 1'b0, 4'd1, 1'b1, rot_l_exp);
        run_op("rot_right", 1'b1, 16'h0001, 1'b1, 4'd1, 1'b1, rot_r_exp);
        run_op("logic_left", 1'b0, 16'h8001, 1'b0, 4'd1, 1'b0, 16'h0002);

        // Reset in the middle of a 15-step shift: nothing may complete.
        @(negedge clk);
        set_inputs(1'b0, 16'h0001, 1'b0, 4'd15, 1'b0);
        @(posedge clk);
        #1;
        check("mid_ack", 32'(ack0), 32'd1);
        @(negedge clk);
        req0 = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ack", {30'd0, ack1, ack0}, 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_answer", 32'(Answer), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        check("post_rst_idle", 32'(busy), 32'd0);
        run_op("after_rst", 1'b0, 16'h0F0F, 1'b1, 4'd4, 1'b0, 16'h00F0);

        do_reset();
        tie_run("tie_after_rst", 16'h0001, 1'b0, 16'h0004, 16'h0004, 1'b1, 16'h0001);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
